// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline blocks: counter-width helper and
// a common valid/data handshake word type.
package pipe_pkg;

    // Default data width of the shared handshake word.
    localparam int HS_WIDTH = 64;

    // Handshake word reused by elastic blocks that carry valid alongside data.
    typedef struct packed {
        logic                       valid;
        logic signed [HS_WIDTH-1:0] data;
    } hs_word_t;

    // Bits needed to count the values 0..depth inclusive.
    function automatic int clog2_cnt(input int depth);
        int w;
        w = 1;
        while ((w < 31) && ((1 << w) <= depth)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One stage of the elastic pipeline: a valid/data register pair that loads
// whenever it can hand its contents onward or is empty.
// Build option: ELASTIC_PIPE_DATA_CLEAR_EN adds a reset to the data register.
module elastic_pipe_stage #(
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    rdy_i,
    input  logic                    src_valid_i,
    input  logic signed [WIDTH-1:0] src_data_i,
    output logic                    v_o,
    output logic signed [WIDTH-1:0] d_o,
    output logic                    rdy_o
);

    logic                    v_q;
    logic                    v_d;
    logic signed [WIDTH-1:0] d_q;
    logic                    d_load;

    // Stage can accept when the stage ahead takes our word or we hold nothing.
    assign rdy_o  = rdy_i | ~v_q;
    assign d_load = rdy_o & src_valid_i;
    assign v_o    = v_q;
    assign d_o    = d_q;

    // Next valid: take the upstream valid when loading, otherwise hold.
    always_comb begin
        v_d = v_q;
        if (rdy_o) begin
            v_d = src_valid_i;
        end
    end

    // Valid register: reset and flush both empty the stage.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
        end
    end

`ifdef ELASTIC_PIPE_DATA_CLEAR_EN
    // Data register with reset, so out_data reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= '0;
        end else if (d_load) begin
            d_q <= src_data_i;
        end
    end
`else
    // Data register without reset; only written when a valid word lands here.
    always_ff @(posedge clk) begin
        if (d_load) begin
            d_q <= src_data_i;
        end
    end
`endif

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: DEPTH stages of signed WIDTH-bit data with a
// combinational ready chain (bubble collapsing), flush and occupancy count.
// Build option: ELASTIC_PIPE_DATA_CLEAR_EN resets the data registers to 0.
module elastic_pipe_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CNT_W = clog2_cnt(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]        occupancy
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("elastic_pipe_reg: DEPTH must be at least 1");
    end

    // Per-stage chain wiring; rdy_w[DEPTH] is the downstream ready.
    logic                    v_w   [DEPTH];
    logic signed [WIDTH-1:0] d_w   [DEPTH];
    logic                    rdy_w [DEPTH+1];

    logic             push;
    logic             pop;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;

    assign rdy_w[DEPTH] = out_ready;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic                    src_valid;
        logic signed [WIDTH-1:0] src_data;

        if (gi == 0) begin : g_head
            // Input side: a flush refuses the incoming word.
            assign src_valid = in_valid & ~flush;
            assign src_data  = in_data;
        end else begin : g_body
            assign src_valid = v_w[gi-1];
            assign src_data  = d_w[gi-1];
        end

        elastic_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .flush_i     (flush),
            .rdy_i       (rdy_w[gi+1]),
            .src_valid_i (src_valid),
            .src_data_i  (src_data),
            .v_o         (v_w[gi]),
            .d_o         (d_w[gi]),
            .rdy_o       (rdy_w[gi])
        );
    end

    assign in_ready  = rdy_w[0] & ~flush;
    assign out_valid = v_w[DEPTH-1];
    assign out_data  = d_w[DEPTH-1];
    assign occupancy = occ_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Occupancy next state: +1 on push, -1 on pop, unchanged on both or neither.
    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

    // Occupancy register: reset and flush empty the pipe.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

endmodule
